// File: rtl/axis_bram_pkg.sv
// axis_bram_pkg: shared FSM state type and BRAM address-width helper for the stream/BRAM blocks
package axis_bram_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_buf_2.sv
// axis_skid_buf_2: 2-entry FIFO; slot0 is always the head, simultaneous push/pop keeps order
module axis_skid_buf_2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] slot0, slot1;
    logic do_push, do_pop;

    assign empty   = count == 2'd0;
    assign full    = count == 2'd2;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = slot0;

    // occupancy and slot shifting; slot1 moves to the head when the head is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
            if (do_push && (empty || (count == 2'd1 && do_pop)))
                slot0 <= din;
            else if (do_pop && full)
                slot0 <= slot1;
            if (do_push && ((count == 2'd1 && !do_pop) || (full && do_pop)))
                slot1 <= din;
        end
    end

endmodule

// File: rtl/axi4_stream_master_bram.sv
// axi4_stream_master_bram: streams DATA_NUM BRAM words as one AXI4-Stream packet; optional out_done via AXIS_MST_BRAM_DONE_EN
module axi4_stream_master_bram import axis_bram_pkg::*; #(
    parameter int DATA_NUM = 11,
    parameter int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = addr_width(DATA_NUM)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    in_start,
    output logic                    out_busy,
    output logic                    out_m_tvalid,
    input  logic                    in_m_tready,
    output logic [DATA_WIDTH-1:0]   out_m_tdata,
    output logic [DATA_WIDTH/8-1:0] out_m_tkeep,
    output logic                    out_m_tlast,
    output logic [ADDR_WIDTH-1:0]   out_A,
    output logic                    out_EN,
    output logic [DATA_WIDTH/8-1:0] out_WE,
    input  logic [DATA_WIDTH-1:0]   in_Do
`ifdef AXIS_MST_BRAM_DONE_EN
    ,
    output logic                    out_done
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_NUM - 1);

    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] rd_cnt, beat_cnt;
    logic rd_pend, issue, hs, full, empty;
    logic [1:0] count;

    axis_skid_buf_2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk  (aclk),
        .rst  (areset),
        .push (rd_pend),
        .din  (in_Do),
        .pop  (hs),
        .dout (out_m_tdata),
        .full (full),
        .empty(empty),
        .count(count)
    );

    assign out_m_tvalid = !empty;
    assign hs           = out_m_tvalid && in_m_tready;
    assign out_m_tlast  = out_m_tvalid && beat_cnt == LAST;
    assign out_m_tkeep  = {(DATA_WIDTH/8){out_m_tvalid}};
    assign out_busy     = state != IDLE;
    assign out_EN       = issue;
    assign out_A        = issue ? rd_cnt : '0;
    assign out_WE       = '0;

    // state register
    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and read issue; a read may replace a beat leaving this cycle so a 1-entry
    // buffer with one read in flight keeps streaming without bubbles
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE:  if (in_start) state_nx = READ;
            READ: begin
                issue = !full && (empty || !rd_pend || hs);
                if (issue && rd_cnt == LAST) state_nx = DRAIN;
            end
            DRAIN: if (hs && out_m_tlast) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // read/beat counters and in-flight flag; counters clear on return to IDLE
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_cnt   <= '0;
            beat_cnt <= '0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= issue;
            if (state_nx == IDLE) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (issue) rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
                if (hs)    beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef AXIS_MST_BRAM_DONE_EN
    // one-cycle completion pulse after the tlast handshake
    always_ff @(posedge aclk) begin
        if (areset) out_done <= 1'b0;
        else        out_done <= hs && out_m_tlast;
    end
`endif

endmodule

// File: tb/tb_axi4_stream_master_bram.sv
// tb_axi4_stream_master_bram: directed table and sequence checks for axi4_stream_master_bram
module tb_axi4_stream_master_bram;

    logic aclk = 1'b0, areset = 1'b1, ready = 1'b1;
    int checks = 0, errors = 0;

    always #5 aclk = ~aclk;

    logic m_start = 1'b0, m_busy, m_valid, m_last, m_en;
    logic [31:0] m_data, m_do;
    logic [3:0] m_keep, m_we, m_a;
    logic x1_start = 1'b0, x1_busy, x1_valid, x1_last, x1_en;
    logic [31:0] x1_data, x1_do;
    logic [3:0] x1_keep, x1_we;
    logic [0:0] x1_a;
    logic x16_start = 1'b0, x16_busy, x16_valid, x16_last, x16_en;
    logic [31:0] x16_data, x16_do;
    logic [3:0] x16_keep, x16_we, x16_a;
`ifdef AXIS_MST_BRAM_DONE_EN
    logic m_done, x1_done, x16_done;
`endif

    axi4_stream_master_bram dut (
        .aclk(aclk), .areset(areset), .in_start(m_start), .out_busy(m_busy),
        .out_m_tvalid(m_valid), .in_m_tready(ready), .out_m_tdata(m_data),
        .out_m_tkeep(m_keep), .out_m_tlast(m_last), .out_A(m_a), .out_EN(m_en),
        .out_WE(m_we), .in_Do(m_do)
`ifdef AXIS_MST_BRAM_DONE_EN
        , .out_done(m_done)
`endif
    );

    axi4_stream_master_bram #(.DATA_NUM(1)) dut1 (
        .aclk(aclk), .areset(areset), .in_start(x1_start), .out_busy(x1_busy),
        .out_m_tvalid(x1_valid), .in_m_tready(ready), .out_m_tdata(x1_data),
        .out_m_tkeep(x1_keep), .out_m_tlast(x1_last), .out_A(x1_a), .out_EN(x1_en),
        .out_WE(x1_we), .in_Do(x1_do)
`ifdef AXIS_MST_BRAM_DONE_EN
        , .out_done(x1_done)
`endif
    );

    axi4_stream_master_bram #(.DATA_NUM(16)) dut16 (
        .aclk(aclk), .areset(areset), .in_start(x16_start), .out_busy(x16_busy),
        .out_m_tvalid(x16_valid), .in_m_tready(ready), .out_m_tdata(x16_data),
        .out_m_tkeep(x16_keep), .out_m_tlast(x16_last), .out_A(x16_a), .out_EN(x16_en),
        .out_WE(x16_we), .in_Do(x16_do)
`ifdef AXIS_MST_BRAM_DONE_EN
        , .out_done(x16_done)
`endif
    );

    // BRAM models with 1-cycle read latency: word i holds base + i
    always_ff @(posedge aclk) begin
        if (m_en)   m_do   <= 32'h100 + 32'(m_a);
        if (x1_en)  x1_do  <= 32'h300 + 32'(x1_a);
        if (x16_en) x16_do <= 32'h200 + 32'(x16_a);
    end

    typedef struct {
        logic start; logic valid; logic [31:0] data; logic last;
        logic busy; logic en; logic [3:0] a; logic done;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // mode 0: ready=1; mode 1: ready 1,0,0,1 repeating; mode 2: ready=1 plus a stray start during beat 5
    task automatic run_pkt(input int mode);
        int got = 0, iss = 0, acc = 0, occ;
        logic last_en = 0, pv = 0, pr = 0, exp_done = 0, ended = 0, stray = 0;
        logic [31:0] pd = 0;
        for (int c = 0; c < 200 && !ended; c++) begin
            @(negedge aclk);
            m_start = (c == 0) || (mode == 2 && got == 5 && !stray);
            if (mode == 2 && got == 5) stray = 1;
            ready = (mode != 1) || (c % 4 == 0) || (c % 4 == 3);
            #1;
`ifdef AXIS_MST_BRAM_DONE_EN
            chk("done_pulse", m_done, exp_done);
`endif
            if (c > 0 && !m_busy) begin
                ended = 1;
            end else begin
                if (pv && !pr) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, pd);
                end
                occ = iss - int'(last_en) - acc;
                if (m_en) chk("no_full_issue", occ < 2, 1);
                exp_done = m_valid && ready && m_last;
                if (m_valid && ready) begin
                    chk("pkt_data", m_data, 32'h100 + got);
                    chk("pkt_last", m_last, got == 10);
                    chk("pkt_keep", m_keep, 4'hF);
                    got++;
                    acc++;
                end
                if (m_en) iss++;
                last_en = m_en;
                pv = m_valid;
                pr = ready;
                pd = m_data;
            end
        end
        m_start = 0;
        ready = 1;
        chk("pkt_ended", ended, 1);
        chk("pkt_beats", got, 11);
    endtask

    initial begin
        for (int i = 0; i < 15; i++) begin
            tbl[i].start = i == 0;
            tbl[i].valid = i >= 3 && i <= 13;
            tbl[i].data  = 32'h100 + 32'(i - 3);
            tbl[i].last  = i == 13;
            tbl[i].busy  = i >= 1 && i <= 13;
            tbl[i].en    = i >= 1 && i <= 11;
            tbl[i].a     = (i >= 1 && i <= 11) ? 4'(i - 1) : 4'd0;
            tbl[i].done  = i == 14;
        end

        repeat (3) @(negedge aclk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_keep", m_keep, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_en", m_en, 0);
        chk("rst_a", m_a, 0);
        chk("rst_we", m_we, 0);
        @(negedge aclk);
        areset = 0;

        for (int i = 0; i < 15; i++) begin
            @(negedge aclk);
            m_start = tbl[i].start;
            #1;
            chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].valid);
            if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), m_data, tbl[i].data);
            chk($sformatf("tbl%0d_keep", i), m_keep, tbl[i].valid ? 4'hF : 4'h0);
            chk($sformatf("tbl%0d_last", i), m_last, tbl[i].last);
            chk($sformatf("tbl%0d_busy", i), m_busy, tbl[i].busy);
            chk($sformatf("tbl%0d_en", i), m_en, tbl[i].en);
            chk($sformatf("tbl%0d_a", i), m_a, tbl[i].a);
            chk($sformatf("tbl%0d_we", i), m_we, 0);
`ifdef AXIS_MST_BRAM_DONE_EN
            chk($sformatf("tbl%0d_done", i), m_done, tbl[i].done);
`endif
        end
        m_start = 0;

        run_pkt(1);
        run_pkt(2);
        run_pkt(0);

        begin
            int got = 0;
            @(negedge aclk);
            m_start = 1;
            for (int c = 0; c < 40 && got < 4; c++) begin
                @(negedge aclk);
                m_start = 0;
                #1;
                if (m_valid) got++;
            end
            chk("rst_mid_reach", got, 4);
            @(negedge aclk);
            areset = 1;
            #1;
            chk("rst_mid_beat4", m_data, 32'h104);
            @(negedge aclk);
            areset = 0;
            #1;
            chk("rst_mid_valid", m_valid, 0);
            chk("rst_mid_en", m_en, 0);
            chk("rst_mid_busy", m_busy, 0);
            chk("rst_mid_last", m_last, 0);
            chk("rst_mid_keep", m_keep, 0);
        end
        run_pkt(0);

        @(negedge aclk);
        x1_start = 1;
        #1;
        chk("n1_idle_busy", x1_busy, 0);
        @(negedge aclk);
        x1_start = 0;
        #1;
        chk("n1_en", x1_en, 1);
        chk("n1_a", x1_a, 0);
        chk("n1_busy", x1_busy, 1);
        @(negedge aclk);
        #1;
        chk("n1_drain_en", x1_en, 0);
        chk("n1_drain_valid", x1_valid, 0);
        @(negedge aclk);
        #1;
        chk("n1_valid", x1_valid, 1);
        chk("n1_data", x1_data, 32'h300);
        chk("n1_last", x1_last, 1);
        chk("n1_keep", x1_keep, 4'hF);
        @(negedge aclk);
        #1;
        chk("n1_end_busy", x1_busy, 0);
        chk("n1_end_valid", x1_valid, 0);

        for (int p = 0; p < 2; p++) begin
            int got = 0, iss = 0;
            logic ended = 0;
            for (int c = 0; c < 60 && !ended; c++) begin
                @(negedge aclk);
                x16_start = c == 0;
                #1;
                if (c > 0 && !x16_busy) begin
                    ended = 1;
                end else begin
                    if (x16_en) begin
                        chk("n16_a", x16_a, iss);
                        iss++;
                    end
                    if (x16_valid) begin
                        chk("n16_data", x16_data, 32'h200 + got);
                        chk("n16_last", x16_last, got == 15);
                        got++;
                    end
                end
            end
            x16_start = 0;
            chk("n16_ended", ended, 1);
            chk("n16_beats", got, 16);
            chk("n16_reads", iss, 16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
